// File: rtl/mat_pkg.sv
// Shared constants and types for the 3x3 matrix load / determinant block.
// The optional feature MAT3_DROP_SINGULAR_EN is handled in mat3_load_det.
package mat_pkg;

    localparam int MAT_DW   = 8;
    localparam int MAT_DETW = 3*MAT_DW + 3;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        DONE
    } state_t;

    // Element indices, row-major: a b c / d e f / g h i
    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;
    localparam int E = 4;
    localparam int F = 5;
    localparam int G = 6;
    localparam int H = 7;
    localparam int I = 8;

    typedef logic [3:0] step_t;

    localparam step_t STEP_M0   = 4'd0;
    localparam step_t STEP_M1   = 4'd1;
    localparam step_t STEP_M2   = 4'd2;
    localparam step_t STEP_M3   = 4'd3;
    localparam step_t STEP_M4   = 4'd4;
    localparam step_t STEP_M5   = 4'd5;
    localparam step_t STEP_A    = 4'd6;
    localparam step_t STEP_B    = 4'd7;
    localparam step_t STEP_C    = 4'd8;
    localparam step_t STEP_LAST = STEP_C;

    localparam logic [3:0] CNT_LAST = 4'd8;

endpackage

// File: rtl/mat3_det_seq.sv
// Sequential 3x3 determinant: one shared signed multiplier, nine steps per matrix.
// Steps 0-5 build the 2x2 minors, steps 6-8 fold them into the cofactor expansion.
module mat3_det_seq
    import mat_pkg::*;
#(
    parameter  int DW   = MAT_DW,
    localparam int DETW = 3*DW + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [9*DW-1:0]        mat,
    output logic                   done,
    output logic signed [DETW-1:0] det
);

    localparam int PW  = 2*DW;
    localparam int DFW = 2*DW + 1;
    localparam int MW  = 3*DW + 1;

    step_t                  step;
    logic signed [DW-1:0]   el [9];
    logic signed [PW-1:0]   m0, m1, m2, m3, m4, m5;
    logic signed [DFW-1:0]  d01, d23, d45;
    logic signed [DW-1:0]   op_a;
    logic signed [DFW-1:0]  op_b;
    logic signed [MW-1:0]   prod;
    logic signed [DETW-1:0] prod_x, acc, acc_next;

    for (genvar k = 0; k < 9; k++) begin : g_el
        assign el[k] = mat[k*DW +: DW];
    end

    function automatic logic signed [DFW-1:0] sx(input logic signed [DW-1:0] v);
        return {{(DFW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [DFW-1:0] diff(input logic signed [PW-1:0] x,
                                                   input logic signed [PW-1:0] y);
        return {x[PW-1], x} - {y[PW-1], y};
    endfunction

    assign d01 = diff(m0, m1);
    assign d23 = diff(m2, m3);
    assign d45 = diff(m4, m5);

    // NOTE: defaults first so every path assigns op_a/op_b and no latch is inferred.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (step)
            STEP_M0: begin op_a = el[E]; op_b = sx(el[I]); end
            STEP_M1: begin op_a = el[F]; op_b = sx(el[H]); end
            STEP_M2: begin op_a = el[D]; op_b = sx(el[I]); end
            STEP_M3: begin op_a = el[F]; op_b = sx(el[G]); end
            STEP_M4: begin op_a = el[D]; op_b = sx(el[H]); end
            STEP_M5: begin op_a = el[E]; op_b = sx(el[G]); end
            STEP_A:  begin op_a = el[A]; op_b = d01;       end
            STEP_B:  begin op_a = el[B]; op_b = d23;       end
            STEP_C:  begin op_a = el[C]; op_b = d45;       end
            default: ;
        endcase
    end

    assign prod   = MW'(op_a) * MW'(op_b);
    assign prod_x = {{(DETW-MW){prod[MW-1]}}, prod};

    always_comb begin
        acc_next = acc;
        case (step)
            STEP_A:  acc_next = prod_x;
            STEP_B:  acc_next = acc - prod_x;
            STEP_C:  acc_next = acc + prod_x;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            step <= STEP_M0;
        end else if (step != STEP_LAST) begin
            step <= step + 4'd1;
        end
    end

    // NOTE: datapath registers carry no reset; every matrix rewrites m0..m5 and acc before reading them.
    always_ff @(posedge clk) begin
        if (run) begin
            case (step)
                STEP_M0: m0 <= prod[PW-1:0];
                STEP_M1: m1 <= prod[PW-1:0];
                STEP_M2: m2 <= prod[PW-1:0];
                STEP_M3: m3 <= prod[PW-1:0];
                STEP_M4: m4 <= prod[PW-1:0];
                STEP_M5: m5 <= prod[PW-1:0];
                default: ;
            endcase
            acc <= acc_next;
        end
    end

    assign done = run && (step == STEP_LAST);
    assign det  = acc_next;

endmodule

// File: rtl/mat3_load_det.sv
// 3x3 matrix loader: buffers nine signed elements, computes the determinant, hands off.
// Define MAT3_DROP_SINGULAR_EN to discard singular matrices and count them on drop_cnt.
module mat3_load_det
    import mat_pkg::*;
#(
    parameter  int DW    = MAT_DW,
    parameter  int CNT_W = 8,
    localparam int DETW  = 3*DW + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [9*DW-1:0]        out_mat,
    output logic signed [DETW-1:0] out_det,
    output logic                   out_singular,
    output logic                   busy
`ifdef MAT3_DROP_SINGULAR_EN
    ,
    output logic [CNT_W-1:0]       drop_cnt
`endif
);

    state_t                 state;
    logic [3:0]             cnt;
    logic [8:0][DW-1:0]     mat_q;
    logic                   accept;
    logic                   det_done;
    logic                   det_zero;
    logic                   drop_now;
    logic signed [DETW-1:0] det_val;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != LOAD) || (cnt != '0);
    assign det_zero = (det_val == '0);

`ifdef MAT3_DROP_SINGULAR_EN
    assign drop_now = det_zero;
`else
    assign drop_now = 1'b0;
`endif

    mat3_det_seq #(.DW(DW)) u_det (
        .clk  (clk),
        .rst  (rst),
        .run  (state == CALC),
        .mat  (mat_q),
        .done (det_done),
        .det  (det_val)
    );

    // Element buffer: the count resets, so stale entries are simply overwritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            mat_q[cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_mat      <= '0;
            out_det      <= '0;
            out_singular <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                CALC: begin
                    if (det_done) begin
                        if (drop_now) begin
                            state <= LOAD;
                        end else begin
                            out_valid    <= 1'b1;
                            out_det      <= det_val;
                            out_singular <= det_zero;
                            out_mat      <= mat_q;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef MAT3_DROP_SINGULAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == CALC && det_done && det_zero && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mat3_load_det.sv
// Self-checking bench for mat3_load_det: directed cases plus random matrices
// compared against a cofactor-expansion reference model.
module tb_mat3_load_det;

    localparam int DW    = 8;
    localparam int DETW  = 3*DW + 3;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [9*DW-1:0]        out_mat;
    logic signed [DETW-1:0] out_det;
    logic                   out_singular;
    logic                   busy;
`ifdef MAT3_DROP_SINGULAR_EN
    logic [CNT_W-1:0]       drop_cnt;
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    mat3_load_det #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mat      (out_mat),
        .out_det      (out_det),
        .out_singular (out_singular),
        .busy         (busy)
`ifdef MAT3_DROP_SINGULAR_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic signed [127:0] got,
                         input logic signed [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint det3(input int v[9]);
        longint a = v[0], b = v[1], c = v[2];
        longint d = v[3], e = v[4], f = v[5];
        longint g = v[6], h = v[7], i = v[8];
        return a*(e*i - f*h) - b*(d*i - f*g) + c*(d*h - e*g);
    endfunction

    task automatic load(input int v[9], input bit gaps);
        for (int k = 0; k < 9; k++) begin
            if (gaps) begin
                int idle = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (idle) begin
                    in_data = DW'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = v[k][DW-1:0];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the ninth element.
    task automatic expect_result(input int v[9], input int stall);
        longint          det = det3(v);
        logic [9*DW-1:0] em;
        int              n;
        for (int k = 0; k < 9; k++) em[k*DW +: DW] = v[k][DW-1:0];
        check("busy_calc", busy, 1);
        check("in_ready_calc", in_ready, 0);
`ifdef MAT3_DROP_SINGULAR_EN
        if (det == 0) begin
            if (exp_drops < (1 << CNT_W) - 1) exp_drops++;
            n = 0;
            repeat (12) begin
                if (out_valid) n++;
                tick();
            end
            check("drop_no_valid", n, 0);
            check("drop_cnt", drop_cnt, exp_drops);
            check("drop_in_ready", in_ready, 1);
            return;
        end
`endif
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check("latency", n, 9);
        check("det", out_det, det);
        check("singular", out_singular, det == 0);
        check("mat", out_mat, em);
        check("in_ready_done", in_ready, 0);
        repeat (stall) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_det", out_det, det);
            check("stall_mat", out_mat, em);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_clear", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int m_id[9]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int m_seq[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int m_diag[9] = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        int m_ext[9]  = '{-128, 127, 0, 0, -128, 127, 127, 0, -128};
        int v[9];
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mat", out_mat, 0);
        check("rst_out_det", out_det, 0);
        check("rst_singular", out_singular, 0);
        check("rst_busy", busy, 0);
`ifdef MAT3_DROP_SINGULAR_EN
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        rst = 1'b0;

        load(m_id, 1'b0);   expect_result(m_id, 0);
        load(m_seq, 1'b0);  expect_result(m_seq, 0);
        load(m_diag, 1'b0); expect_result(m_diag, 5);
        load(m_ext, 1'b0);  expect_result(m_ext, 0);

        // Reset after four elements, with in_valid still asserted on the reset edge.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = DW'(m_ext[k]);
            tick();
        end
        check("busy_partial", busy, 1);
        in_data = 8'h55;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_load_busy", busy, 0);
        check("rst_load_in_ready", in_ready, 1);
        load(m_diag, 1'b0); expect_result(m_diag, 0);

        // Reset while the sequencer sits on step 5.
        load(m_id, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_calc_busy", busy, 0);
        check("rst_calc_valid", out_valid, 0);
        check("rst_calc_mat", out_mat, 0);
        check("rst_calc_det", out_det, 0);
        n = 0;
        repeat (15) begin
            if (out_valid) n++;
            tick();
        end
        check("rst_calc_no_valid", n, 0);

        load(m_id, 1'b1); expect_result(m_id, 0);

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 9; k++) v[k] = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 3; k++) v[3+k] = v[k];
            end
            load(v, 1'($urandom_range(0, 1)));
            expect_result(v, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat3_load_det.md
Name: mat3_load_det

Overview:
- Upstream feeder for the matrix-inverse stage.
- Accepts a signed 3x3 matrix one element per handshake, in row-major order, and buffers it.
- Computes the determinant sequentially using a single shared multiplier.
- Presents the matrix, determinant and singular flag to the inverse stage over a valid/ready handshake.

Parameters:
- DW, 8, signed element width in two's complement.
- CNT_W, 8, width of the dropped-matrix counter (used only with the optional feature).
- Derived localparam DETW = 3*DW+3 (27 at default). This is the lossless determinant width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  element present on in_data.
- in_ready  out  1  block can accept an element.
- in_data  in  DW  signed element, order a,b,c,d,e,f,g,h,i.
- out_valid  out  1  matrix and determinant valid.
- out_ready  in  1  inverse stage accepts the result.
- out_mat  out  9*DW  buffered matrix; element a at [DW-1:0], i at [9*DW-1:8*DW].
- out_det  out  DETW  signed determinant.
- out_singular  out  1  out_det == 0.
- busy  out  1  state != LOAD or element count != 0.
- drop_cnt  out  CNT_W  dropped singular matrices; exists only with the optional feature.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_mat=0, out_det=0, out_singular=0, busy=0, drop_cnt=0. State goes to LOAD and the element count to 0.
- State LOAD:
  - in_ready=1.
  - Each edge with in_valid&in_ready stores in_data at the current count and increments the count (0..8).
  - The edge that accepts element 8 (edge T) sets count=0, state=CALC, step=0.
- State CALC:
  - in_ready=0. One multiply per cycle, step 0..8; products are full 2*DW signed.
  - Steps 0-5 load minor registers: m0=e*i, m1=f*h, m2=d*i, m3=f*g, m4=d*h, m5=e*g.
  - Step 6: acc = a*(m0-m1).
  - Step 7: acc = acc - b*(m2-m3).
  - Step 8: acc = acc + c*(m4-m5).
  - All differences and sums are sign-extended to DETW; no truncation or saturation.
  - At the step-8 edge (T+9): out_det=acc result, out_singular=(result==0), out_valid=1, state=DONE.
  - Latency: out_valid is high 9 cycles after the edge that accepts the last element.
- State DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0. in_ready=0, so no new element is accepted.
  - The edge with out_valid&out_ready clears out_valid and returns to LOAD.
  - in_ready becomes 1 in the following cycle; there is no same-cycle load overlap.
- out_mat updates only on the transition into DONE. It is stable throughout DONE.
- in_valid while in_ready=0 is ignored; no data is stored.
- rst at any point (mid-LOAD, CALC or DONE) discards the partial matrix and any pending result. It restores reset values on that edge; the next accepted element is element a.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: MAT3_DROP_SINGULAR_EN.
- Defined:
  - A singular result never asserts out_valid. The block returns from CALC straight to LOAD.
  - drop_cnt increments, saturating at all-ones.
  - out_singular is then always 0 when out_valid=1.
- Undefined:
  - Singular matrices are presented normally with out_singular=1.
  - The drop_cnt port and its counter are absent.

Decomposition:
- Shared package mat_pkg holds:
  - DW and DETW defaults;
  - the state enum (LOAD, CALC, DONE);
  - element index constants A..I (0..8);
  - the step constants.
- One natural sub-module, mat3_det_seq: the step counter, operand mux, shared multiplier and accumulator.
- The top level keeps the element buffer and the handshake logic.

Test Plan:
- Identity 1,0,0,0,1,0,0,0,1, out_ready=1 -> out_det=1, out_singular=0, out_valid exactly 9 cycles after the 9th accept, out_mat echoes input.
- 1,2,3,4,5,6,7,8,9 -> out_det=0, out_singular=1 (with MAT3_DROP_SINGULAR_EN: no out_valid, drop_cnt=1).
- Diagonal 2,0,0,0,3,0,0,0,4 -> out_det=24. Extremes -128,127,0,0,-128,127,127,0,-128 -> out_det=-48769, no overflow.
- out_ready low for 5 cycles in DONE -> out_valid, out_det and out_mat stable, in_ready=0. in_valid pulses are ignored; the next matrix starts fresh after acceptance.
- rst after 4 elements accepted, then a full diagonal 2,0,0,0,3,0,0,0,4 -> out_det=24 (stale elements unused). rst during CALC step 5 -> no out_valid, busy=0 next cycle.
- in_valid toggling randomly (gaps) while loading identity -> same result as the gapless case. Only handshaken cycles advance the count.
